// File: rtl/deser_3s_8b_if.sv
// Handshake and data bundle between a serial bit source and the
// deser_3s_8b receiver. The source side drives the control/data bits,
// the receiver side returns the assembled byte and status.
interface deser_3s_8b_if;
  logic       start;
  logic       en;
  logic       d;
  logic       clr;
  logic [7:0] o;
  logic [2:0] s;
  logic       busy;
  logic       done;

  modport master (
    output start, en, d, clr,
    input  o, s, busy, done
  );

  modport slave (
    input  start, en, d, clr,
    output o, s, busy, done
  );
endinterface : deser_3s_8b_if

// File: rtl/deser_3s_8b.sv
// Sequential 1-to-8 demultiplexer: rebuilds a byte from eight accepted
// serial bits, steering each bit by a 3-bit select counter. Receive end
// of the select-swept 8:1 mux serializer.
module deser_3s_8b #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  deser_3s_8b_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] buf_q;
  logic [7:0] o_q;
  logic [2:0] s_q;
  logic       busy_q;
  logic       done_q;

  logic [2:0] pos_d;
  logic [7:0] buf_d;

  // Byte position addressed by the current select value.
  assign pos_d = LSB_FIRST ? s_q : (3'd7 - s_q);

  // Partial byte with the incoming bit dropped into its slot.
  always_comb begin
    // NOTE: assign a full default first so no path leaves buf_d unassigned,
    // which would otherwise infer a latch.
    buf_d        = buf_q;
    buf_d[pos_d] = bus.d;
  end

  // Receive FSM with registered outputs; done is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= 8'h00;
      o_q     <= 8'h00;
      s_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; a later assignment in the branch overrides this.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // clr outranks start, so an abort request also blocks arming.
          if (bus.start && !bus.clr) begin
            state_q <= RECV;
            busy_q  <= 1'b1;
            s_q     <= 3'd0;
            buf_q   <= 8'h00;
          end
        end
        RECV: begin
          if (bus.clr) begin
            // Abort: partial byte dropped, o keeps the last full byte.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            s_q     <= 3'd0;
            buf_q   <= 8'h00;
          end else if (bus.en) begin
            buf_q <= buf_d;
            s_q   <= s_q + 3'd1;
            if (s_q == 3'd7) begin
              // Eighth bit: publish the byte and return to IDLE so start
              // can be taken in the done cycle.
              o_q     <= buf_d;
              done_q  <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o    = o_q;
  assign bus.s    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : deser_3s_8b

// File: doc/deser_3s_8b.md
Name: deser_3s_8b

Overview:
- Sequential 1-to-8 demultiplexer: the receive end of the 3-bit-select, 8-input serializing mux path.
- Accepts one serial bit per enabled cycle and routes it to the byte position given by an internal 3-bit select counter.
- After 8 accepted bits it presents the assembled byte and pulses done.
- It sits opposite the mux-based serializer, so a byte sent by sweeping select 0..7 is rebuilt here unchanged.

Parameters:
- LSB_FIRST, 1: 1 = first accepted bit goes to o[0] and the counter steps 0 to 7. 0 = first bit goes to o[7] and the position steps 7 down to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  arms reception of a new byte; sampled only in IDLE.
- en  input  1  serial bit valid; d is captured on a rising edge when en=1 in RECV.
- d  input  1  serial data bit.
- clr  input  1  synchronous abort of the byte in progress.
- o  output  8  last completed byte, registered; held until the next completion.
- s  output  3  current select / bit index, registered; counts accepted bits (0..7).
- busy  output  1  1 while in RECV.
- done  output  1  one-cycle pulse; o is valid and new in the same cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE, o=8'h00, s=3'd0, busy=0, done=0, internal buffer=8'h00. Takes effect immediately regardless of clk; released state is IDLE.
- States: IDLE, RECV. A separate registered done flag models the pulse.
- IDLE:
  - busy=0.
  - start=1 at an edge -> RECV, s<=0, buffer<=8'h00.
  - d/en in the start cycle are ignored; the first bit is captured on the next enabled edge.
- RECV:
  - busy=1.
  - Each edge with en=1: buffer[pos]<=d, s<=s+1. pos = s when LSB_FIRST=1, pos = 7-s when LSB_FIRST=0.
  - en=0: no change, so gaps of any length are allowed.
- Completion:
  - Edge with en=1 and s==7 -> o<=buffer with bit pos replaced by d.
  - Same edge: done<=1, s<=0 (3-bit wrap), state<=IDLE.
  - Result: done and the new o are visible in the cycle after the 8th accepted bit.
  - done is 1 for exactly one cycle and cleared on the next edge unconditionally.
- Back-to-back bytes: start may be asserted in the cycle done=1 (state already IDLE), so the next byte needs no idle gap beyond the start cycle.
- start while in RECV: ignored; it neither restarts reception nor resets s.
- clr=1 at an edge:
  - In RECV: -> IDLE, s<=0, buffer discarded, o unchanged, done stays 0.
  - In IDLE: no effect.
  - clr has priority over en and start in the same edge.
- clr and the 8th bit on the same edge: clr wins, no completion, o unchanged.
- Reset mid-byte: all outputs take their reset values immediately; the partial byte is lost.
- s is a plain 3-bit counter; no other arithmetic.
- o never shows partial data; only complete bytes update o.

Test Plan:
- LSB_FIRST=1:
  - Reset, start, then d=1,0,1,0,0,1,0,1 with en=1 on 8 consecutive edges -> done high for exactly 1 cycle one cycle after the 8th edge, o=8'hA5, busy falls with done, s=0.
  - Same byte sent with en toggling 1,0,1,0 (16 cycles) -> o=8'hA5, done single pulse; s holds its value across en=0 cycles.
- Send 8'h3C, then start during the done cycle and send 8'hC3 -> o=8'h3C then 8'hC3, two separate done pulses, no lost bits. start asserted during RECV of the second byte has no effect on s.
- After 8'hA5 is complete, start and feed 4 bits of 8'h0F, then assert clr -> IDLE, busy=0, s=0, no done, o still 8'hA5. Repeat with clr on the same edge as the 8th bit -> no done, o=8'hA5.
- rst pulsed asynchronously between clock edges at s=5 -> o=8'h00, s=0, busy=0, done=0 immediately. A following full byte 8'h81 completes normally.
- LSB_FIRST=0: bits 1,0,1,0,0,1,0,1 -> o=8'hA5 (first bit into o[7]). Bits 1,1,0,0,0,0,0,0 -> o=8'hC0.
